// File: rtl/mips_mem_pkg.sv
// Shared definitions for the Mips memory-side bridge.
// Holds the bridge state encoding, the SRAM/CPU bus widths and the
// level used for an inactive (deasserted) active-low SRAM strobe.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam int CPU_DW  = 32;

    localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/sram_phase_timer.sv
// Phase timer for one 16-bit SRAM phase.
// Ports:
//   clock, reset      - clock and asynchronous active-low reset
//   load             - phase entry; reloads the down-counter with WAIT_CYCLES
//   phase_last       - current cycle is the last cycle of the phase
//   phase_last_next  - the cycle after the coming edge is the last phase cycle
//                      (lets the bridge register its strobes one cycle ahead)
module sram_phase_timer
    import mips_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic phase_last,
    output logic phase_last_next
);

    localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

    logic [2:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= 3'd0;
        end else if (load) begin
            count <= WAIT_LD;
        end else if (count != 3'd0) begin
            count <= count - 3'd1;
        end
    end

    assign phase_last      = (count == 3'd0);
    assign phase_last_next = load ? (WAIT_LD == 3'd0) : (count <= 3'd1);

endmodule

// File: rtl/mips_sram_bridge.sv
// Bridge from one 32-bit byte-enabled CPU access to one or two 16-bit
// accesses on an asynchronous 256Kx16 SRAM.
// Ports:
//   clock, reset          - clock, asynchronous active-low reset
//   req, we, cpu_addr,
//   wdata, byte_en        - CPU request (sampled only when idle)
//   rdata, ack, busy      - read data, one-cycle completion pulse, busy flag
//   addr, data            - SRAM halfword address and bidirectional data bus
//   wre, oute, chip_en,
//   hb_mask, lb_mask      - SRAM strobes, all active-low and registered
module mips_sram_bridge
    import mips_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req,
    input  logic                we,
    input  logic [CPU_DW-1:0]   cpu_addr,
    input  logic [CPU_DW-1:0]   wdata,
    input  logic [3:0]          byte_en,
    output logic [CPU_DW-1:0]   rdata,
    output logic                ack,
    output logic                busy,
    output logic [SRAM_AW-1:0]  addr,
    inout  wire  [SRAM_DW-1:0]  data,
    output logic                wre,
    output logic                oute,
    output logic                chip_en,
    output logic                hb_mask,
    output logic                lb_mask
);

    state_t state, state_d;

    // Latched request
    logic                we_q;
    logic [16:0]         word_q;
    logic [CPU_DW-1:0]   wdata_q;
    logic [3:0]          be_q;

    // Request as seen this cycle: live inputs while idle, latched copy after
    logic                cur_we;
    logic [16:0]         cur_word;
    logic [CPU_DW-1:0]   cur_wdata;
    logic [3:0]          cur_be;

    logic                in_phase_d, half_d, load;
    logic [1:0]          be_half;
    logic                phase_last, phase_last_next;

    logic [SRAM_AW-1:0]  addr_d;
    logic [SRAM_DW-1:0]  data_out, data_out_d, rd_lo;
    logic                data_oe, data_oe_d;
    logic                wre_d, oute_d, chip_en_d, hb_mask_d, lb_mask_d;

    logic                unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:19], cpu_addr[1:0]};

    sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
        .clock           (clock),
        .reset           (reset),
        .load            (load),
        .phase_last      (phase_last),
        .phase_last_next (phase_last_next)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        cur_we    = we_q;
        cur_word  = word_q;
        cur_wdata = wdata_q;
        cur_be    = be_q;
        if (state == IDLE) begin
            cur_we    = we;
            cur_word  = cpu_addr[18:2];
            cur_wdata = wdata;
            cur_be    = byte_en;
        end

        case (state)
            IDLE: begin
                if (req) begin
                    if (we && byte_en == 4'b0000)       state_d = DONE;
                    else if (we && byte_en[1:0] == 2'b00) state_d = HI;
                    else                                 state_d = LO;
                end
            end
            LO: begin
                if (phase_last) begin
                    state_d = (we_q && be_q[3:2] == 2'b00) ? DONE : HI;
                end
            end
            HI: begin
                if (phase_last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are computed from the state the
        // bridge is about to enter.
        in_phase_d = (state_d == LO) || (state_d == HI);
        half_d     = (state_d == HI);
        load       = in_phase_d && (state_d != state);
        be_half    = half_d ? cur_be[3:2] : cur_be[1:0];

        addr_d     = addr;
        data_out_d = data_out;
        if (in_phase_d) begin
            addr_d     = {cur_word, half_d};
            data_out_d = half_d ? cur_wdata[31:16] : cur_wdata[15:0];
        end

        chip_en_d = in_phase_d ? 1'b0 : STROBE_OFF;
        oute_d    = (in_phase_d && !cur_we) ? 1'b0 : STROBE_OFF;
        // wre rises into the last phase cycle so addr/data are stable at
        // its rising edge; a single-cycle phase keeps it low throughout.
        wre_d     = (in_phase_d && cur_we && ((WAIT_CYCLES == 0) || !phase_last_next))
                    ? 1'b0 : STROBE_OFF;
        hb_mask_d = STROBE_OFF;
        lb_mask_d = STROBE_OFF;
        if (in_phase_d) begin
            hb_mask_d = cur_we ? ~be_half[1] : 1'b0;
            lb_mask_d = cur_we ? ~be_half[0] : 1'b0;
        end

        // With no wait cycles the write data is held through DONE to give
        // hold time after wre rises.
        data_oe_d = cur_we && (in_phase_d ||
                    ((WAIT_CYCLES == 0) && (state_d == DONE) &&
                     ((state == LO) || (state == HI))));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr    <= '0;
            chip_en <= STROBE_OFF;
            oute    <= STROBE_OFF;
            wre     <= STROBE_OFF;
            hb_mask <= STROBE_OFF;
            lb_mask <= STROBE_OFF;
            data_oe <= 1'b0;
            ack     <= 1'b0;
            busy    <= 1'b0;
            rdata   <= '0;
        end else begin
            addr    <= addr_d;
            chip_en <= chip_en_d;
            oute    <= oute_d;
            wre     <= wre_d;
            hb_mask <= hb_mask_d;
            lb_mask <= lb_mask_d;
            data_oe <= data_oe_d;
            ack     <= (state_d == DONE);
            busy    <= (state_d != IDLE);
            // Full word is published only when the upper half arrives so
            // rdata holds the previous read until this one completes.
            if (!we_q && state == HI && phase_last) begin
                rdata <= {data, rd_lo};
            end
        end
    end

    always_ff @(posedge clock) begin
        data_out <= data_out_d;
        if (state == IDLE && req) begin
            we_q    <= we;
            word_q  <= cpu_addr[18:2];
            wdata_q <= wdata;
            be_q    <= byte_en;
        end
        if (!we_q && state == LO && phase_last) begin
            rd_lo <= data;
        end
    end

    assign data = data_oe ? data_out : 16'hzzzz;

endmodule

// File: tb/tb_mips_sram_bridge.sv
// Directed bench for mips_sram_bridge: three instances (WAIT_CYCLES 1, 0, 3)
// sharing one behavioural SRAM array.
module tb_mips_sram_bridge;

    logic        clock;
    logic        reset;
    logic        req_m, req_0, req_3;
    logic        we;
    logic [31:0] cpu_addr, wdata;
    logic [3:0]  byte_en;

    logic [31:0] rdata_m, rdata_0, rdata_3;
    logic        ack_m, ack_0, ack_3, busy_m, busy_0, busy_3;
    logic [17:0] addr_m, addr_0, addr_3;
    wire  [15:0] data_m, data_0, data_3;
    logic        wre_m, oute_m, ce_m, hb_m, lb_m;
    logic        wre_0, oute_0, ce_0, hb_0, lb_0;
    logic        wre_3, oute_3, ce_3, hb_3, lb_3;

    logic [15:0] mem [0:262143];

    int n_checks = 0;
    int n_fail   = 0;

    // monitor state
    int          oute_cnt, ce_cnt, wre_run, wre_max, wre_pulses, conflicts;
    logic [17:0] first_oaddr, last_oaddr, last_caddr;
    logic        last_hb, last_lb;

    mips_sram_bridge #(.WAIT_CYCLES(1)) u_m (
        .clock(clock), .reset(reset), .req(req_m), .we(we), .cpu_addr(cpu_addr),
        .wdata(wdata), .byte_en(byte_en), .rdata(rdata_m), .ack(ack_m), .busy(busy_m),
        .addr(addr_m), .data(data_m), .wre(wre_m), .oute(oute_m), .chip_en(ce_m),
        .hb_mask(hb_m), .lb_mask(lb_m));

    mips_sram_bridge #(.WAIT_CYCLES(0)) u_0 (
        .clock(clock), .reset(reset), .req(req_0), .we(we), .cpu_addr(cpu_addr),
        .wdata(wdata), .byte_en(byte_en), .rdata(rdata_0), .ack(ack_0), .busy(busy_0),
        .addr(addr_0), .data(data_0), .wre(wre_0), .oute(oute_0), .chip_en(ce_0),
        .hb_mask(hb_0), .lb_mask(lb_0));

    mips_sram_bridge #(.WAIT_CYCLES(3)) u_3 (
        .clock(clock), .reset(reset), .req(req_3), .we(we), .cpu_addr(cpu_addr),
        .wdata(wdata), .byte_en(byte_en), .rdata(rdata_3), .ack(ack_3), .busy(busy_3),
        .addr(addr_3), .data(data_3), .wre(wre_3), .oute(oute_3), .chip_en(ce_3),
        .hb_mask(hb_3), .lb_mask(lb_3));

    // SRAM read model: drives the bus while selected with output enabled
    assign data_m = (!ce_m && !oute_m) ? mem[addr_m] : 16'hzzzz;
    assign data_0 = (!ce_0 && !oute_0) ? mem[addr_0] : 16'hzzzz;
    assign data_3 = (!ce_3 && !oute_3) ? mem[addr_3] : 16'hzzzz;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        oute_cnt = 0; ce_cnt = 0; wre_run = 0; wre_max = 0; wre_pulses = 0;
        first_oaddr = '0; last_oaddr = '0; last_caddr = '0;
        last_hb = 1'b0; last_lb = 1'b0;
    endtask

    // Monitor and SRAM write model for the WAIT_CYCLES=1 instance
    always @(negedge clock) begin
        if (!oute_m) begin
            if (oute_cnt == 0) first_oaddr = addr_m;
            last_oaddr = addr_m;
            oute_cnt++;
            if (u_m.data_oe || !wre_m) conflicts++;
        end
        if (!ce_m) begin
            ce_cnt++;
            last_hb    = hb_m;
            last_lb    = lb_m;
            last_caddr = addr_m;
        end
        if (!wre_m) begin
            wre_run++;
        end else if (wre_run != 0) begin
            wre_pulses++;
            if (wre_run > wre_max) wre_max = wre_run;
            wre_run = 0;
        end
        if (!ce_m && !wre_m) begin
            if (!lb_m) mem[addr_m][7:0]  = data_m[7:0];
            if (!hb_m) mem[addr_m][15:8] = data_m[15:8];
        end
    end

    task automatic do_access(input int sel, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be,
                             output int lat, output logic [31:0] rd);
        logic hit;
        @(negedge clock);
        we = w; cpu_addr = a; wdata = d; byte_en = be;
        if (sel == 0) req_m = 1'b1; else if (sel == 1) req_0 = 1'b1; else req_3 = 1'b1;
        @(posedge clock);
        #1;
        req_m = 1'b0; req_0 = 1'b0; req_3 = 1'b0;
        lat = -1;
        rd  = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            hit = (sel == 0) ? ack_m : (sel == 1) ? ack_0 : ack_3;
            if (hit) begin
                lat = c + 1;
                rd  = (sel == 0) ? rdata_m : (sel == 1) ? rdata_0 : rdata_3;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, k;
        logic [31:0] rd;
        int          ack_seen;

        conflicts = 0;
        clr_mon();
        reset = 1'b0;
        req_m = 1'b0; req_0 = 1'b0; req_3 = 1'b0;
        we = 1'b0; cpu_addr = '0; wdata = '0; byte_en = '0;
        mem[18'h00A00] = 16'h1234;
        mem[18'h00A01] = 16'hABCD;
        mem[18'h01004] = 16'h5678;
        mem[18'h01005] = 16'h9ABC;
        mem[18'h01800] = 16'h0000;
        mem[18'h01801] = 16'h0000;

        // Reset values
        #12;
        check_val("rst_strobes", {27'd0, ce_m, wre_m, oute_m, hb_m, lb_m}, 32'h1F);
        check_val("rst_addr", {14'd0, addr_m}, 32'h0);
        check_val("rst_rdata", rdata_m, 32'h0);
        check_val("rst_ack_busy", {30'd0, ack_m, busy_m}, 32'h0);
        check_val("rst_bus_release", {31'd0, u_m.data_oe}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Word read
        clr_mon();
        do_access(0, 1'b0, 32'h0000_1400, 32'h0, 4'hF, lat, rd);
        check_val("rd_latency", lat, 32'd5);
        check_val("rd_data", rd, 32'hABCD_1234);
        check_val("rd_oute_cycles", oute_cnt, 32'd4);
        check_val("rd_addr_lo", {14'd0, first_oaddr}, 32'h00A00);
        check_val("rd_addr_hi", {14'd0, last_oaddr}, 32'h00A01);
        repeat (3) @(negedge clock);
        check_val("rd_hold", rdata_m, 32'hABCD_1234);

        // Word write
        clr_mon();
        do_access(0, 1'b1, 32'h0000_1400, 32'hDEAD_BEEF, 4'b1111, lat, rd);
        check_val("sw_latency", lat, 32'd5);
        check_val("sw_mem_lo", {16'd0, mem[18'h00A00]}, 32'hBEEF);
        check_val("sw_mem_hi", {16'd0, mem[18'h00A01]}, 32'hDEAD);
        check_val("sw_wre_pulses", wre_pulses, 32'd2);
        check_val("sw_wre_width", wre_max, 32'd1);

        // Byte write to byte 2 (HI phase only)
        clr_mon();
        do_access(0, 1'b1, 32'h0000_1400, 32'h0055_0000, 4'b0100, lat, rd);
        check_val("sb_latency", lat, 32'd3);
        check_val("sb_ce_cycles", ce_cnt, 32'd2);
        check_val("sb_masks", {30'd0, last_hb, last_lb}, 32'h2);
        check_val("sb_addr", {14'd0, last_caddr}, 32'h00A01);
        check_val("sb_mem_hi", {16'd0, mem[18'h00A01]}, 32'hDE55);
        check_val("sb_mem_lo", {16'd0, mem[18'h00A00]}, 32'hBEEF);

        // Back-to-back: read then byte_en=0000 write with req held high
        clr_mon();
        @(negedge clock);
        we = 1'b0; cpu_addr = 32'h0000_1400; wdata = '0; byte_en = 4'hF; req_m = 1'b1;
        @(posedge clock);
        lat = -1;
        for (k = 0; k < 40; k++) begin
            @(negedge clock);
            if (ack_m) begin
                lat = k + 1;
                break;
            end
        end
        check_val("b2b_rd_latency", lat, 32'd5);
        check_val("b2b_rd_data", rdata_m, 32'hDE55_BEEF);
        we = 1'b1; byte_en = 4'b0000;
        clr_mon();
        @(negedge clock);
        check_val("b2b_idle_gap", {30'd0, ack_m, busy_m}, 32'h0);
        @(negedge clock);
        check_val("b2b_wr_ack", {30'd0, ack_m, busy_m}, 32'h3);
        req_m = 1'b0;
        @(negedge clock);
        check_val("b2b_ack_pulse", {30'd0, ack_m, busy_m}, 32'h0);
        check_val("b2b_no_strobe", ce_cnt, 32'd0);
        check_val("bus_conflicts", conflicts, 32'd0);

        // Reset asserted in the middle of a write
        @(negedge clock);
        we = 1'b1; cpu_addr = 32'h0000_3000; wdata = 32'h1111_2222; byte_en = 4'hF; req_m = 1'b1;
        @(posedge clock);
        #1 req_m = 1'b0;
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check_val("abort_strobes", {27'd0, ce_m, wre_m, oute_m, hb_m, lb_m}, 32'h1F);
        check_val("abort_bus_release", {31'd0, u_m.data_oe}, 32'h0);
        check_val("abort_busy", {31'd0, busy_m}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        ack_seen = 0;
        repeat (10) begin
            @(negedge clock);
            if (ack_m) ack_seen++;
        end
        check_val("abort_no_ack", ack_seen, 32'd0);

        // WAIT_CYCLES = 0 and 3
        do_access(1, 1'b0, 32'h0000_2008, 32'h0, 4'hF, lat, rd);
        check_val("w0_latency", lat, 32'd3);
        check_val("w0_data", rd, 32'h9ABC_5678);
        do_access(2, 1'b0, 32'h0000_2008, 32'h0, 4'hF, lat, rd);
        check_val("w3_latency", lat, 32'd9);
        check_val("w3_data", rd, 32'h9ABC_5678);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
